// File: rtl/mcpu_pkg.sv
// Shared widths, FSM state encoding and timing constants for the MCPU memory responder.
package mcpu_pkg;

  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 8;
  localparam int HOLD_LEN = 2;
  localparam int HOLD_W   = $clog2(HOLD_LEN);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [HOLD_W-1:0] hold_t;

  localparam hold_t HOLD_LAST = hold_t'(HOLD_LEN - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mcpu_ram64x8.sv
// 64x8 storage: one synchronous write port, one asynchronous read port.
module mcpu_ram64x8
  import mcpu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic  clk,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  data_t wr_data,
  input  addr_t rd_addr,
  output data_t rd_data
);

  data_t mem [DEPTH];

  // NOTE: no reset on the array -- program contents must survive rst and an aborted load.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mcpu_mem_responder.sv
// CPU-facing memory with mapped I/O ports and a streaming program loader that holds the CPU in reset.
module mcpu_mem_responder
  import mcpu_pkg::*;
#(
  parameter int    MEM_DEPTH = 64,
  parameter addr_t OUT_ADDR  = 6'h3F,
  parameter addr_t IN_ADDR   = 6'h3E
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] adress,
  input  logic              oe,
  input  logic              we,
  output logic              cpu_rst,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_start,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_stb
);

  state_t state, state_nxt;
  addr_t  ld_cnt;
  hold_t  hold_cnt;

  logic   load_hs, cpu_rd, cpu_wr;
  logic   wr_en;
  addr_t  wr_addr;
  data_t  wr_data, ram_rd, rd_val;

  assign ld_ready = rst && (state == LOAD);
  assign cpu_rst  = rst && (state == RUN);
  assign load_hs  = ld_valid && ld_ready;

  // oe and we low together is a bus conflict and counts as neither access.
  assign cpu_rd = rst && (state == RUN) && !oe && we;
  assign cpu_wr = rst && (state == RUN) && !we && oe && (adress != IN_ADDR);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (ld_start) state_nxt = LOAD;
      LOAD:    if (load_hs && (ld_cnt == '1)) state_nxt = HOLD;
      HOLD:    if (hold_cnt == HOLD_LAST) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_cnt   <= '0;
      hold_cnt <= '0;
      out_port <= '0;
      out_stb  <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      // The counter wraps 63 -> 0 on the final handshake.
      if ((state == RUN) && ld_start) ld_cnt <= '0;
      else if (load_hs)               ld_cnt <= ld_cnt + 1'b1;

      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else               hold_cnt <= '0;

      if (cpu_wr && (adress == OUT_ADDR)) begin
        out_port <= data;
        out_stb  <= 1'b1;
      end
    end
  end

  // The loader and the CPU never write in the same cycle: they own disjoint FSM states.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = adress;
    wr_data = data;
    if (load_hs) begin
      wr_en   = 1'b1;
      wr_addr = ld_cnt;
      wr_data = ld_data;
    end else if (cpu_wr) begin
      wr_en = 1'b1;
    end
  end

  mcpu_ram64x8 #(
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (adress),
    .rd_data (ram_rd)
  );

  always_comb begin
    if (adress == IN_ADDR)       rd_val = in_port;
    else if (adress == OUT_ADDR) rd_val = out_port;
    else                         rd_val = ram_rd;
  end

  assign data = cpu_rd ? rd_val : {DATA_W{1'bz}};

endmodule

// File: doc/mcpu_mem_responder.md
MCPU_MEM_RESPONDER -- requirements
Module: mcpu_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, number of 8-bit words; fixed to 2^6 by the address width.
REQ-002 SHALL have parameter OUT_ADDR, default 6'h3F, address of the memory-mapped output port.
REQ-003 SHALL have parameter IN_ADDR, default 6'h3E, address of the memory-mapped input port.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 data  inout  8  shared CPU data bus; driven by this block only during reads.
REQ-007 adress  input  6  CPU address.
REQ-008 oe  input  1  read strobe, active-low.
REQ-009 we  input  1  write strobe, active-low.
REQ-010 cpu_rst  output  1  active-low reset to the CPU; low while loading.
REQ-011 ld_valid  input  1  loader byte valid.
REQ-012 ld_data  input  8  loader byte.
REQ-013 ld_ready  output  1  loader byte accepted when ld_valid and ld_ready are both high on a rising edge.
REQ-014 ld_start  input  1  single-cycle pulse that starts a program load.
REQ-015 in_port  input  8  external input byte.
REQ-016 out_port  output  8  registered output byte.
REQ-017 out_stb  output  1  one-cycle pulse on each out_port update.

Function
REQ-018 SHALL implement a state machine with states RUN, LOAD and HOLD.
REQ-019 RUN: ld_ready low, cpu_rst high, CPU bus active.
REQ-020 RUN -> LOAD on ld_start; the load counter clears to 0 and cpu_rst goes low in the same edge.
REQ-021 LOAD: ld_ready high; each handshake writes ld_data to mem[counter] and increments the counter.
REQ-022 The load counter SHALL be 6 bits; the handshake at counter 63 writes word 63, wraps the counter to 0 and moves to HOLD.
REQ-023 ld_start during LOAD or HOLD SHALL be ignored.
REQ-024 HOLD: ld_ready low, cpu_rst low for exactly 2 cycles, then RUN with cpu_rst high.
REQ-025 The CPU bus SHALL be ignored in LOAD and HOLD, and data SHALL stay tri-stated.
REQ-026 RUN read: data is driven combinationally when oe is low, we is high and rst is high; otherwise data is Z.
REQ-027 Read value: in_port if adress==IN_ADDR, out_port if adress==OUT_ADDR, else mem[adress].
REQ-028 RUN write: on a rising edge with we sampled low, oe sampled high and adress!=IN_ADDR, data is written to mem[adress].
REQ-029 A RUN write to OUT_ADDR SHALL also load out_port and pulse out_stb on the following cycle.
REQ-030 A write to IN_ADDR SHALL be discarded.
REQ-031 oe and we low in the same cycle SHALL be treated as neither: no drive and no write.
REQ-032 A held-low we SHALL write on every cycle it is sampled low; out_stb pulses once per cycle.
REQ-033 Read latency is zero cycles (combinational); write latency is one edge.

Reset
REQ-034 When rst is low, the state SHALL enter RUN, counter=0, out_port=0, out_stb=0, ld_ready=0, and data SHALL be Z.
REQ-035 When rst is low, cpu_rst SHALL be low.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 A reset during LOAD SHALL abort the load; words already written are kept.

Structure
REQ-038 A shared package mcpu_pkg SHALL hold the address and data widths, the state enum (RUN/LOAD/HOLD) and the HOLD length constant 2.
REQ-039 The storage array SHALL be a sub-module mcpu_ram64x8: one synchronous write port, one asynchronous read port, arbitrated by a write mux between the loader and the CPU.

Verification
REQ-040 Load 64 bytes 0x00..0x3F with ld_valid held high -> ld_ready high for 64 cycles, cpu_rst low for 66 cycles total, then high; mem[i]==i.
REQ-041 Backpressure: ld_valid toggled every other cycle -> exactly 64 words written in order with no duplicates or skips.
REQ-042 RUN, we low, adress=0x3F, data=0xA5 -> out_port==0xA5 and out_stb high for exactly 1 cycle; a read of 0x3F returns 0xA5.
REQ-043 in_port=0x5A, oe low, adress=0x3E -> data==0x5A; a write of 0xFF to 0x3E leaves the 0x3E read unchanged.
REQ-044 oe and we both low at adress 0x10 -> data is Z and mem[0x10] is unchanged.
REQ-045 rst low after 10 load bytes, then released -> state RUN, cpu_rst high, mem[0..9] loaded, ld_ready low.
